// File: rtl/axi_full_mst_burst.sv
// AXI4-full burst initiator: one command becomes one INCR burst on AW/W/B or AR/R,
// with write beats streamed from a local source and read beats streamed to a local sink.
module axi_full_mst_burst #(
   parameter int unsigned DW = 128,
   parameter int unsigned AW = 32,
   parameter int unsigned IW = 4,
   parameter int unsigned ID = 0
) (
   input  logic            CLK,
   input  logic            RSTn,
   // command
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_wr,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [7:0]      cmd_len,
   // write beat source
   input  logic            wd_valid,
   output logic            wd_ready,
   input  logic [DW-1:0]   wd_data,
   input  logic [DW/8-1:0] wd_strb,
   // read beat sink
   output logic            rd_valid,
   input  logic            rd_ready,
   output logic [DW-1:0]   rd_data,
   output logic            rd_last,
   // completion
   output logic            done_valid,
   output logic [1:0]      done_resp,
   // AW channel
   output logic [IW-1:0]   MEM_AWID,
   output logic [AW-1:0]   MEM_AWADDR,
   output logic [7:0]      MEM_AWLEN,
   output logic [2:0]      MEM_AWSIZE,
   output logic [1:0]      MEM_AWBURST,
   output logic            MEM_AWVALID,
   input  logic            MEM_AWREADY,
   // W channel
   output logic [DW-1:0]   MEM_WDATA,
   output logic [DW/8-1:0] MEM_WSTRB,
   output logic            MEM_WLAST,
   output logic            MEM_WVALID,
   input  logic            MEM_WREADY,
   // B channel
   input  logic [IW-1:0]   MEM_BID,
   input  logic [1:0]      MEM_BRESP,
   input  logic            MEM_BVALID,
   output logic            MEM_BREADY,
   // AR channel
   output logic [IW-1:0]   MEM_ARID,
   output logic [AW-1:0]   MEM_ARADDR,
   output logic [7:0]      MEM_ARLEN,
   output logic [2:0]      MEM_ARSIZE,
   output logic [1:0]      MEM_ARBURST,
   output logic            MEM_ARVALID,
   input  logic            MEM_ARREADY,
   // R channel
   input  logic [IW-1:0]   MEM_RID,
   input  logic [DW-1:0]   MEM_RDATA,
   input  logic [1:0]      MEM_RRESP,
   input  logic            MEM_RLAST,
   input  logic            MEM_RVALID,
   output logic            MEM_RREADY
);

   localparam int unsigned SZ = $clog2(DW/8);
   localparam int unsigned XW = 14 + SZ;   // wide enough for addr[11:0] + 256 beats of bytes
   localparam int unsigned CW = 9;         // 256 beats must not wrap the counter

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_A,
      ST_WR_D,
      ST_WR_B,
      ST_RD_A,
      ST_RD_D
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [7:0]      len_q, len_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      resp_q, resp_d;
   logic            done_valid_q, done_valid_d;
   logic [1:0]      done_resp_q, done_resp_d;
   logic            awvalid_q, awvalid_d;
   logic            arvalid_q, arvalid_d;

   logic            last_beat_c;
   logic            cross_4k_c;
   logic            r_bad_c;
   logic [XW-1:0]   burst_end_c;
   logic [AW-1:0]   addr_aligned_c;

   // Burst geometry and per-beat status
   assign last_beat_c    = (cnt_q == {1'b0, len_q});
   assign addr_aligned_c = {cmd_addr[AW-1:SZ], {SZ{1'b0}}};
   assign burst_end_c    = XW'(cmd_addr[11:0]) + ((XW'(cmd_len) + XW'(1)) << SZ);
   assign cross_4k_c     = (burst_end_c > XW'(4096));
   assign r_bad_c        = (MEM_RRESP != RESP_OKAY) || (MEM_RID != IW'(ID)) ||
                           (MEM_RLAST != last_beat_c);

   // Command / completion
   assign cmd_ready   = (state_q == ST_IDLE);
   assign done_valid  = done_valid_q;
   assign done_resp   = done_resp_q;

   // Address bundles share one registered address/length
   assign MEM_AWID    = IW'(ID);
   assign MEM_AWADDR  = addr_q;
   assign MEM_AWLEN   = len_q;
   assign MEM_AWSIZE  = 3'(SZ);
   assign MEM_AWBURST = 2'b01;
   assign MEM_AWVALID = awvalid_q;
   assign MEM_ARID    = IW'(ID);
   assign MEM_ARADDR  = addr_q;
   assign MEM_ARLEN   = len_q;
   assign MEM_ARSIZE  = 3'(SZ);
   assign MEM_ARBURST = 2'b01;
   assign MEM_ARVALID = arvalid_q;

   // Write data pass-through, gated by the data phase
   assign MEM_WVALID  = (state_q == ST_WR_D) && wd_valid;
   assign wd_ready    = (state_q == ST_WR_D) && MEM_WREADY;
   assign MEM_WDATA   = wd_data;
   assign MEM_WSTRB   = wd_strb;
   assign MEM_WLAST   = (state_q == ST_WR_D) && last_beat_c;
   assign MEM_BREADY  = (state_q == ST_WR_B);

   // Read data pass-through, gated by the data phase
   assign rd_valid    = (state_q == ST_RD_D) && MEM_RVALID;
   assign MEM_RREADY  = (state_q == ST_RD_D) && rd_ready;
   assign rd_data     = MEM_RDATA;
   assign rd_last     = (state_q == ST_RD_D) && last_beat_c;

   // Next-state and registered-output logic
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      cnt_d        = cnt_q;
      resp_d       = resp_q;
      done_valid_d = 1'b0;
      done_resp_d  = done_resp_q;
      awvalid_d    = awvalid_q;
      arvalid_d    = arvalid_q;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d = addr_aligned_c;
               len_d  = cmd_len;
               cnt_d  = '0;
               resp_d = RESP_OKAY;
               if (cross_4k_c) begin
                  // Refused without any bus traffic; completion reported next cycle
                  done_valid_d = 1'b1;
                  done_resp_d  = RESP_SLVERR;
               end else if (cmd_wr) begin
                  awvalid_d = 1'b1;
                  state_d   = ST_WR_A;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = ST_RD_A;
               end
            end
         end
         ST_WR_A: begin
            if (MEM_AWREADY) begin
               awvalid_d = 1'b0;
               state_d   = ST_WR_D;
            end
         end
         ST_WR_D: begin
            if (MEM_WVALID && MEM_WREADY) begin
               if (last_beat_c) begin
                  cnt_d   = '0;
                  state_d = ST_WR_B;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         ST_WR_B: begin
            if (MEM_BVALID) begin
               done_valid_d = 1'b1;
               done_resp_d  = ((MEM_BRESP == RESP_OKAY) && (MEM_BID == IW'(ID))) ?
                              RESP_OKAY : RESP_SLVERR;
               state_d      = ST_IDLE;
            end
         end
         ST_RD_A: begin
            if (MEM_ARREADY) begin
               arvalid_d = 1'b0;
               state_d   = ST_RD_D;
            end
         end
         ST_RD_D: begin
            if (MEM_RVALID && MEM_RREADY) begin
               resp_d = r_bad_c ? RESP_SLVERR : resp_q;
               if (last_beat_c) begin
                  // Length is owned locally; RLAST only feeds the error check
                  cnt_d        = '0;
                  done_valid_d = 1'b1;
                  done_resp_d  = r_bad_c ? RESP_SLVERR : resp_q;
                  state_d      = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q      <= ST_IDLE;
         addr_q       <= '0;
         len_q        <= '0;
         cnt_q        <= '0;
         resp_q       <= RESP_OKAY;
         done_valid_q <= 1'b0;
         done_resp_q  <= RESP_OKAY;
         awvalid_q    <= 1'b0;
         arvalid_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         len_q        <= len_d;
         cnt_q        <= cnt_d;
         resp_q       <= resp_d;
         done_valid_q <= done_valid_d;
         done_resp_q  <= done_resp_d;
         awvalid_q    <= awvalid_d;
         arvalid_q    <= arvalid_d;
      end
   end

endmodule
